imm_ext_pipe: RTL

- Parametrised, pipelined immediate-extension unit for the datapath.
- Widens an IN_W-bit instruction immediate to OUT_W bits in one of four modes: sign, zero, upper-load, branch-offset.
- Uses valid/ready handshakes on both sides and has a 2-entry skid buffer, so it can sit between decode and execute pipeline stages without combinational ready paths.
- Successor to the fixed 16->32 combinational sign extender.

---
 rtl/imm_ext_pipe.sv | 129 ++++++++++++
 1 files changed

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: pipelined immediate extender with valid/ready on both sides.
// An output register (O) and a skid register (S) let in_ready be a pure flop,
// so there is no combinational path from out_ready back to in_ready.
//
// Handshake: a word moves across an interface on a rising clk edge when both
// valid and ready are high at that edge. A producer holding valid=1 keeps its
// payload stable until the transfer happens. The output side keeps
// out_data/out_mode stable while out_valid=1 and out_ready=0.
module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode,
  output logic [1:0]       dbg_state
);

  // The BOFF shift must not drop significant bits.
  if (OUT_W < IN_W + 2) begin : g_width_check
    $error("imm_ext_pipe: OUT_W must be >= IN_W + 2");
  end

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam int PAD_W = OUT_W - IN_W;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [OUT_W-1:0] o_data_q, o_data_d;
  logic [1:0]       o_mode_q, o_mode_d;
  logic [OUT_W-1:0] s_data_q, s_data_d;
  logic [1:0]       s_mode_q, s_mode_d;

  logic [OUT_W-1:0] ext_sext;
  logic [OUT_W-1:0] ext_data;
  logic             accept;

  // Extend the incoming immediate according to its mode.
  always_comb begin
    ext_sext = {{PAD_W{in_data[IN_W-1]}}, in_data};
    ext_data = ext_sext;
    case (in_mode)
      2'b00:   ext_data = ext_sext;
      2'b01:   ext_data = {{PAD_W{1'b0}}, in_data};
      2'b10:   ext_data = {in_data, {PAD_W{1'b0}}};
      default: ext_data = {ext_sext[OUT_W-3:0], 2'b00};
    endcase
  end

  assign accept = in_valid && in_ready_q;

  // Occupancy FSM and next values for the O and S registers.
  always_comb begin
    state_d  = state_q;
    o_data_d = o_data_q;
    o_mode_d = o_mode_q;
    s_data_d = s_data_q;
    s_mode_d = s_mode_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          o_data_d = ext_data;
          o_mode_d = in_mode;
          state_d  = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && out_ready) begin
          o_data_d = ext_data;
          o_mode_d = in_mode;
        end else if (accept) begin
          s_data_d = ext_data;
          s_mode_d = in_mode;
          state_d  = ST_FULL;
        end else if (out_ready) begin
          state_d  = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the skid drain can happen.
        if (out_ready) begin
          o_data_d = s_data_q;
          o_mode_d = s_mode_q;
          state_d  = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    in_ready_d = (state_d != ST_FULL);
  end

  // State, ready and data registers; reset discards all held words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
      o_data_q   <= '0;
      o_mode_q   <= 2'b00;
      s_data_q   <= '0;
      s_mode_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      o_data_q   <= o_data_d;
      o_mode_q   <= o_mode_d;
      s_data_q   <= s_data_d;
      s_mode_q   <= s_mode_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = o_data_q;
  assign out_mode  = o_mode_q;
  assign dbg_state = state_q;

endmodule
